// File: rtl/cache_mem_sched.sv
// Memory channel scheduler shared by I$ refill and D$ refill/writeback.
// One transaction in flight; each 32-byte line moves as two 128-bit beats.
module cache_mem_sched #(
    parameter int TIDW   = 6,
    parameter int LADDRW = 27,
    parameter int IDXW   = 3
) (
    input  logic              gclk,
    input  logic              rst,

    input  logic              ireq_valid,
    input  logic [TIDW-1:0]   ireq_tid,
    input  logic [LADDRW-1:0] ireq_laddr,
    output logic              ireq_ready,

    input  logic              dreq_valid,
    input  logic              dreq_wb,
    input  logic [TIDW-1:0]   dreq_tid,
    input  logic [LADDRW-1:0] dreq_laddr,
    input  logic [255:0]      dreq_wdata,
    output logic              dreq_ready,

    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [LADDRW-1:0] mem_cmd_laddr,
    input  logic              mem_cmd_ready,
    output logic              mem_wdata_valid,
    output logic [127:0]      mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic              mem_rdata_valid,
    input  logic [127:0]      mem_rdata,

    output logic              cram_we,
    output logic              cram_dsel,
    output logic [TIDW-1:0]   cram_tid,
    output logic [IDXW-1:0]   cram_index,
    output logic              cram_half,
    output logic [127:0]      cram_data,

    output logic              done_valid,
    output logic              done_dsel,
    output logic [TIDW-1:0]   done_tid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WD0,
        S_WD1,
        S_RD0,
        S_RD1,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic                dsel_q, dsel_d;
    logic                we_q, we_d;
    logic [TIDW-1:0]     tid_q, tid_d;
    logic [LADDRW-1:0]   laddr_q, laddr_d;
    logic [255:0]        wdata_q, wdata_d;
    logic                grant_d;

    // rr_last holds the side granted last (1 = D$), so a tie goes to the other side.
    assign grant_d = (ireq_valid && dreq_valid) ? ~rr_last_q : dreq_valid;

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
            dsel_q    <= 1'b0;
            we_q      <= 1'b0;
            tid_q     <= '0;
            laddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            dsel_q    <= dsel_d;
            we_q      <= we_d;
            tid_q     <= tid_d;
            laddr_q   <= laddr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_last_d       = rr_last_q;
        dsel_d          = dsel_q;
        we_d            = we_q;
        tid_d           = tid_q;
        laddr_d         = laddr_q;
        wdata_d         = wdata_q;

        ireq_ready      = 1'b0;
        dreq_ready      = 1'b0;
        mem_cmd_valid   = 1'b0;
        mem_cmd_we      = 1'b0;
        mem_cmd_laddr   = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        cram_we         = 1'b0;
        cram_dsel       = 1'b0;
        cram_tid        = '0;
        cram_index      = '0;
        cram_half       = 1'b0;
        cram_data       = '0;
        done_valid      = 1'b0;
        done_dsel       = 1'b0;
        done_tid        = '0;

        case (state_q)
            S_IDLE: begin
                // Ready is masked while reset is held so that every output reads 0.
                if (!rst && (ireq_valid || dreq_valid)) begin
                    rr_last_d = grant_d;
                    dsel_d    = grant_d;
                    state_d   = S_CMD;
                    if (grant_d) begin
                        dreq_ready = 1'b1;
                        we_d       = dreq_wb;
                        tid_d      = dreq_tid;
                        laddr_d    = dreq_laddr;
                        wdata_d    = dreq_wdata;
                    end else begin
                        ireq_ready = 1'b1;
                        we_d       = 1'b0;
                        tid_d      = ireq_tid;
                        laddr_d    = ireq_laddr;
                        wdata_d    = '0;
                    end
                end
            end
            S_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = we_q;
                mem_cmd_laddr = laddr_q;
                if (mem_cmd_ready) begin
                    state_d = we_q ? S_WD0 : S_RD0;
                end
            end
            S_WD0: begin
                mem_wdata_valid = 1'b1;
                mem_wdata       = wdata_q[127:0];
                if (mem_wdata_ready) begin
                    state_d = S_WD1;
                end
            end
            S_WD1: begin
                mem_wdata_valid = 1'b1;
                mem_wdata       = wdata_q[255:128];
                if (mem_wdata_ready) begin
                    state_d = S_DONE;
                end
            end
            S_RD0, S_RD1: begin
                // Read data has no backpressure: it goes straight to the line RAM.
                if (mem_rdata_valid) begin
                    cram_we    = 1'b1;
                    cram_dsel  = dsel_q;
                    cram_tid   = tid_q;
                    cram_index = laddr_q[IDXW-1:0];
                    cram_half  = (state_q == S_RD1);
                    cram_data  = mem_rdata;
                    state_d    = (state_q == S_RD1) ? S_DONE : S_RD1;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                done_dsel  = dsel_q;
                done_tid   = tid_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_sched.sv
// Self-checking bench for cache_mem_sched: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_cache_mem_sched;

    localparam int TIDW   = 6;
    localparam int LADDRW = 27;
    localparam int IDXW   = 3;

    logic              gclk;
    logic              rst;
    logic              ireq_valid;
    logic [TIDW-1:0]   ireq_tid;
    logic [LADDRW-1:0] ireq_laddr;
    logic              ireq_ready;
    logic              dreq_valid;
    logic              dreq_wb;
    logic [TIDW-1:0]   dreq_tid;
    logic [LADDRW-1:0] dreq_laddr;
    logic [255:0]      dreq_wdata;
    logic              dreq_ready;
    logic              mem_cmd_valid;
    logic              mem_cmd_we;
    logic [LADDRW-1:0] mem_cmd_laddr;
    logic              mem_cmd_ready;
    logic              mem_wdata_valid;
    logic [127:0]      mem_wdata;
    logic              mem_wdata_ready;
    logic              mem_rdata_valid;
    logic [127:0]      mem_rdata;
    logic              cram_we;
    logic              cram_dsel;
    logic [TIDW-1:0]   cram_tid;
    logic [IDXW-1:0]   cram_index;
    logic              cram_half;
    logic [127:0]      cram_data;
    logic              done_valid;
    logic              done_dsel;
    logic [TIDW-1:0]   done_tid;

    int n_tests = 0;
    int n_fail  = 0;
    bit rr_model;   // side granted last; 1 = D$

    cache_mem_sched #(.TIDW(TIDW), .LADDRW(LADDRW), .IDXW(IDXW)) dut (
        .gclk(gclk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_tid(ireq_tid), .ireq_laddr(ireq_laddr), .ireq_ready(ireq_ready),
        .dreq_valid(dreq_valid), .dreq_wb(dreq_wb), .dreq_tid(dreq_tid), .dreq_laddr(dreq_laddr),
        .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we), .mem_cmd_laddr(mem_cmd_laddr),
        .mem_cmd_ready(mem_cmd_ready), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
        .mem_wdata_ready(mem_wdata_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .cram_we(cram_we), .cram_dsel(cram_dsel), .cram_tid(cram_tid), .cram_index(cram_index),
        .cram_half(cram_half), .cram_data(cram_data),
        .done_valid(done_valid), .done_dsel(done_dsel), .done_tid(done_tid)
    );

    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    task automatic edge1();
        @(posedge gclk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Runs one granted transaction to completion. The caller has driven the request
    // inputs and the DUT is idle. The model picks the winner, strips its request after
    // the grant and checks every channel phase against the expected line contents.
    task automatic run_txn(input int cmd_stall, input int dat_stall, input bit spur,
                           input logic [127:0] rd0, input logic [127:0] rd1);
        bit                exp_d;
        bit                ewb;
        logic [TIDW-1:0]   etid;
        logic [LADDRW-1:0] eladdr;
        logic [255:0]      ewdata;
        logic [127:0]      rd;
        logic [127:0]      ebeat;
        exp_d  = (ireq_valid && dreq_valid) ? !rr_model : dreq_valid;
        ewb    = exp_d ? dreq_wb : 1'b0;
        etid   = exp_d ? dreq_tid : ireq_tid;
        eladdr = exp_d ? dreq_laddr : ireq_laddr;
        ewdata = dreq_wdata;
        $display("[TB] txn %s tid=%0d laddr=%h cmd_stall=%0d dat_stall=%0d",
                 exp_d ? (ewb ? "DWB" : "DLD") : "ILD", etid, eladdr, cmd_stall, dat_stall);
        #2;
        n_tests++;
        if ({ireq_ready, dreq_ready} !== {!exp_d, exp_d}) begin
            n_fail++;
            $display("FAIL grant got i=%b d=%b exp i=%b d=%b", ireq_ready, dreq_ready, !exp_d, exp_d);
        end
        rr_model = exp_d;
        edge1();
        if (exp_d) dreq_valid = 1'b0; else ireq_valid = 1'b0;

        for (int i = 0; i <= cmd_stall; i++) begin
            mem_cmd_ready   = (i == cmd_stall);
            mem_rdata_valid = spur;
            mem_rdata       = rnd128();
            #2;
            n_tests++;
            if ({mem_cmd_valid, mem_cmd_we, mem_cmd_laddr} !== {1'b1, ewb, eladdr}) begin
                n_fail++;
                $display("FAIL cmd got v=%b we=%b la=%h exp v=1 we=%b la=%h",
                         mem_cmd_valid, mem_cmd_we, mem_cmd_laddr, ewb, eladdr);
            end
            n_tests++;
            if ({cram_we, ireq_ready, dreq_ready, done_valid} !== 4'b0) begin
                n_fail++;
                $display("FAIL cmd_quiet got cram_we=%b rdy=%b%b done=%b exp 0",
                         cram_we, ireq_ready, dreq_ready, done_valid);
            end
            edge1();
        end
        mem_cmd_ready   = 1'b0;
        mem_rdata_valid = 1'b0;

        for (int b = 0; b < 2; b++) begin
            ebeat = (b == 0) ? ewdata[127:0] : ewdata[255:128];
            rd    = (b == 0) ? rd0 : rd1;
            for (int i = 0; i <= dat_stall; i++) begin
                if (ewb) begin
                    mem_wdata_ready = (i == dat_stall);
                    #2;
                    n_tests++;
                    if ({mem_wdata_valid, mem_wdata, cram_we, mem_cmd_valid} !== {1'b1, ebeat, 2'b00}) begin
                        n_fail++;
                        $display("FAIL wbeat%0d got v=%b d=%h cram_we=%b cmd=%b exp v=1 d=%h",
                                 b, mem_wdata_valid, mem_wdata, cram_we, mem_cmd_valid, ebeat);
                    end
                end else begin
                    mem_rdata_valid = (i == dat_stall);
                    mem_rdata       = (i == dat_stall) ? rd : rnd128();
                    #2;
                    n_tests++;
                    if (i == dat_stall) begin
                        if ({cram_we, cram_half, cram_dsel, cram_tid, cram_index, cram_data} !==
                            {1'b1, b[0], exp_d, etid, eladdr[IDXW-1:0], rd}) begin
                            n_fail++;
                            $display("FAIL rbeat%0d got we=%b h=%b ds=%b tid=%0d idx=%0d d=%h exp we=1 h=%0d ds=%b tid=%0d idx=%0d d=%h",
                                     b, cram_we, cram_half, cram_dsel, cram_tid, cram_index, cram_data,
                                     b, exp_d, etid, eladdr[IDXW-1:0], rd);
                        end
                    end else if (cram_we !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rgap%0d got cram_we=%b exp 0", b, cram_we);
                    end
                end
                n_tests++;
                if ({ireq_ready, dreq_ready, done_valid} !== 3'b0) begin
                    n_fail++;
                    $display("FAIL data_quiet got rdy=%b%b done=%b exp 0", ireq_ready, dreq_ready, done_valid);
                end
                edge1();
            end
            mem_wdata_ready = 1'b0;
            mem_rdata_valid = 1'b0;
        end

        #2;
        n_tests++;
        if ({done_valid, done_dsel, done_tid, ireq_ready, dreq_ready, cram_we, mem_wdata_valid} !==
            {1'b1, exp_d, etid, 4'b0}) begin
            n_fail++;
            $display("FAIL done got v=%b ds=%b tid=%0d rdy=%b%b cram_we=%b wv=%b exp v=1 ds=%b tid=%0d",
                     done_valid, done_dsel, done_tid, ireq_ready, dreq_ready, cram_we, mem_wdata_valid,
                     exp_d, etid);
        end
        edge1();
        #2;
        n_tests++;
        if (done_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got done_valid=%b after done exp 0", done_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ireq_valid = 1'b1; ireq_tid = 6'd1; ireq_laddr = 27'h1;
        dreq_valid = 1'b1; dreq_wb = 1'b1; dreq_tid = 6'd2; dreq_laddr = 27'h2; dreq_wdata = '1;
        mem_cmd_ready = 1'b1; mem_wdata_ready = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = '1;
        edge1();
        edge1();
        n_tests++;
        if ({ireq_ready, dreq_ready, mem_cmd_valid, mem_cmd_we, mem_cmd_laddr, mem_wdata_valid, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_req_mem got nonzero rdy=%b%b cmd=%b we=%b la=%h wv=%b exp 0",
                     ireq_ready, dreq_ready, mem_cmd_valid, mem_cmd_we, mem_cmd_laddr, mem_wdata_valid);
        end
        n_tests++;
        if ({cram_we, cram_dsel, cram_tid, cram_index, cram_half, cram_data, done_valid, done_dsel, done_tid} !== '0) begin
            n_fail++;
            $display("FAIL reset_cram_done got we=%b d=%h done=%b exp 0", cram_we, cram_data, done_valid);
        end
        ireq_valid = 1'b0; dreq_valid = 1'b0; dreq_wb = 1'b0; dreq_wdata = '0;
        mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        rr_model = 1'b1;
        edge1();
    endtask

    task automatic test_icache_ld();
        ireq_valid = 1'b1; ireq_tid = 6'd5; ireq_laddr = 27'h0000123;
        run_txn(0, 0, 1'b0, {32{4'hA}}, {32{4'hB}});
    endtask

    task automatic test_dcache_wb();
        dreq_valid = 1'b1; dreq_wb = 1'b1; dreq_tid = 6'd9; dreq_laddr = 27'h4ABCDEF;
        dreq_wdata = {{32{4'hB}}, {32{4'hA}}};
        run_txn(0, 0, 1'b0, '0, '0);
    endtask

    task automatic test_arbitration();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        rr_model = 1'b1;
        edge1();
        for (int r = 0; r < 3; r++) begin
            ireq_valid = 1'b1; ireq_tid = 6'($urandom_range(0, 63)); ireq_laddr = 27'($urandom());
            dreq_valid = 1'b1; dreq_wb = 1'($urandom_range(0, 1)); dreq_tid = 6'($urandom_range(0, 63));
            dreq_laddr = 27'($urandom()); dreq_wdata = {rnd128(), rnd128()};
            run_txn(0, 0, 1'b0, rnd128(), rnd128());
            run_txn(0, 0, 1'b0, rnd128(), rnd128());
        end
    endtask

    task automatic test_stalls();
        dreq_valid = 1'b1; dreq_wb = 1'b1; dreq_tid = 6'd33; dreq_laddr = 27'h7FFFFFF;
        dreq_wdata = {rnd128(), rnd128()};
        run_txn(5, 3, 1'b0, '0, '0);
        ireq_valid = 1'b1; ireq_tid = 6'd63; ireq_laddr = 27'h0000007;
        run_txn(4, 2, 1'b0, rnd128(), rnd128());
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = rnd128();
            #2;
            n_tests++;
            if ({cram_we, done_valid, mem_cmd_valid} !== 3'b0) begin
                n_fail++;
                $display("FAIL spur_idle got cram_we=%b done=%b cmd=%b exp 0", cram_we, done_valid, mem_cmd_valid);
            end
            edge1();
        end
        mem_rdata_valid = 1'b0;
        dreq_valid = 1'b1; dreq_wb = 1'b0; dreq_tid = 6'd17; dreq_laddr = 27'h0ABCDE5;
        run_txn(3, 1, 1'b1, rnd128(), rnd128());
    endtask

    task automatic test_reset_mid();
        logic [127:0] rd;
        ireq_valid = 1'b1; ireq_tid = 6'd12; ireq_laddr = 27'h0000042;
        #2;
        edge1();
        ireq_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        edge1();
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata = rnd128();
        edge1();
        rd = rnd128();
        mem_rdata = rd;
        #1;
        n_tests++;
        if ({cram_we, cram_half, cram_data} !== {2'b11, rd}) begin
            n_fail++;
            $display("FAIL mid_rd1 got we=%b h=%b d=%h exp we=1 h=1 d=%h", cram_we, cram_half, cram_data, rd);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({cram_we, cram_dsel, cram_tid, cram_index, cram_half, cram_data, done_valid, done_tid,
             mem_cmd_valid, mem_wdata_valid, ireq_ready, dreq_ready} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got we=%b h=%b d=%h done=%b exp all 0", cram_we, cram_half, cram_data, done_valid);
        end
        edge1();
        rst = 1'b0;
        rr_model = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_tests++;
            if ({done_valid, cram_we, mem_cmd_valid} !== 3'b0) begin
                n_fail++;
                $display("FAIL post_reset got done=%b cram_we=%b cmd=%b exp 0", done_valid, cram_we, mem_cmd_valid);
            end
            edge1();
        end
        mem_rdata_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if (!ireq_valid && ($urandom_range(0, 1) == 1)) begin
                ireq_valid = 1'b1; ireq_tid = 6'($urandom_range(0, 63)); ireq_laddr = 27'($urandom());
            end
            if (!dreq_valid && ($urandom_range(0, 1) == 1)) begin
                dreq_valid = 1'b1; dreq_wb = 1'($urandom_range(0, 1)); dreq_tid = 6'($urandom_range(0, 63));
                dreq_laddr = 27'($urandom()); dreq_wdata = {rnd128(), rnd128()};
            end
            if (!ireq_valid && !dreq_valid) begin
                ireq_valid = 1'b1; ireq_tid = 6'($urandom_range(0, 63)); ireq_laddr = 27'($urandom());
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)), rnd128(), rnd128());
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_icache_ld();
        test_dcache_wb();
        test_arbitration();
        test_stalls();
        test_spurious();
        test_reset_mid();
        test_icache_ld();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
